// File: rtl/wb_commit_queue_if.sv
// rtl/wb_commit_queue_if.sv - MEM-to-WB result bus and register-file commit port bundle
//
// Purpose: groups every handshake/data signal of wb_commit_queue so the queue
// and its neighbours connect through one port. clk and resetn stay outside.
//
// Signals (MEM side drives, WB side consumes unless noted):
//   mem_to_wb_valid   MEM beat valid
//   wb_allow_in       (WB out) WB accepts a beat this cycle
//   mem_lane_valid    per-lane valid, lane 0 oldest
//   mem_pc            per-lane PC, lane i at [32i+31:32i]
//   mem_final_result  per-lane result
//   mem_reg_we        per-lane register write enable
//   mem_reg_waddr     per-lane destination register
//   wb_flush          drop queued entries and the current beat
//   wb_commit_ready   register-file port accepts a write
//   wb_to_id_valid .. debug_wb_rf_wdata  (WB out) head entry, hazard mask, trace
//
// Modports: master = MEM/register-file environment, slave = wb_commit_queue.

interface wb_commit_queue_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                    mem_to_wb_valid;
  logic                    wb_allow_in;
  logic [LANES-1:0]        mem_lane_valid;
  logic [LANES*32-1:0]     mem_pc;
  logic [LANES*DATA_W-1:0] mem_final_result;
  logic [LANES-1:0]        mem_reg_we;
  logic [LANES*ADDR_W-1:0] mem_reg_waddr;
  logic                    wb_flush;
  logic                    wb_commit_ready;
  logic                    wb_to_id_valid;
  logic                    wb_reg_we;
  logic [ADDR_W-1:0]       wb_reg_waddr;
  logic [DATA_W-1:0]       wb_final_result;
  logic [2**ADDR_W-1:0]    wb_pending_mask;
  logic [31:0]             debug_wb_pc;
  logic [3:0]              debug_wb_rf_wen;
  logic [ADDR_W-1:0]       debug_wb_rf_wnum;
  logic [DATA_W-1:0]       debug_wb_rf_wdata;

  modport master (
    output mem_to_wb_valid, mem_lane_valid, mem_pc, mem_final_result,
           mem_reg_we, mem_reg_waddr, wb_flush, wb_commit_ready,
    input  wb_allow_in, wb_to_id_valid, wb_reg_we, wb_reg_waddr,
           wb_final_result, wb_pending_mask, debug_wb_pc, debug_wb_rf_wen,
           debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  mem_to_wb_valid, mem_lane_valid, mem_pc, mem_final_result,
           mem_reg_we, mem_reg_waddr, wb_flush, wb_commit_ready,
    output wb_allow_in, wb_to_id_valid, wb_reg_we, wb_reg_waddr,
           wb_final_result, wb_pending_mask, debug_wb_pc, debug_wb_rf_wen,
           debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - multi-lane in-order writeback queue with single commit port
//
// Purpose: accepts up to LANES results per MEM beat, compacts the valid lanes
// into a DEPTH-entry circular queue and retires one entry per cycle to the
// register-file write port. Publishes a pending-write mask for ID hazard
// detection and the debug writeback trace.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     wb_commit_queue_if.slave (MEM beat in, commit port / trace out)

module wb_commit_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  wb_commit_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2 ** ADDR_W;

  // Queue storage
  logic [31:0]       r_pc     [DEPTH];
  logic [DATA_W-1:0] r_result [DEPTH];
  logic [ADDR_W-1:0] r_waddr  [DEPTH];
  logic [DEPTH-1:0]  r_we;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_allow_in;
  logic              w_accept;
  logic              w_head_valid;
  logic              w_pop;
  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_nvalid;
  logic [CNT_W-1:0]  w_add;
  logic [PTR_W-1:0]  w_slot [LANES];
  logic [NREG-1:0]   w_mask;

  // Space check uses only the registered count, so there is no path from
  // wb_commit_ready or the MEM beat into wb_allow_in.
  assign w_free       = CNT_W'(DEPTH) - r_count;
  assign w_allow_in   = (w_free >= CNT_W'(LANES)) & ~bus.wb_flush;
  assign w_accept     = bus.mem_to_wb_valid & w_allow_in;
  assign w_head_valid = (r_count != '0);
  assign w_pop        = w_head_valid & bus.wb_commit_ready;
  assign w_add        = w_accept ? w_nvalid : '0;

  // Lane compaction: each valid lane lands at tail plus the number of valid
  // lanes older than it, so invalid lanes leave no hole in the queue.
  always_comb begin
    w_nvalid = '0;
    for (int i = 0; i < LANES; i++) begin
      w_slot[i] = r_tail + w_nvalid[PTR_W-1:0];
      w_nvalid  = w_nvalid + CNT_W'(bus.mem_lane_valid[i]);
    end
  end

  // Pending-write mask: an entry is live when its distance from head is
  // below count. Register 0 is never reported as a hazard.
  always_comb begin
    logic [PTR_W-1:0] v_rel;
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_rel = PTR_W'(i) - r_head;
      if ((CNT_W'(v_rel) < r_count) && r_we[i]) begin
        w_mask[r_waddr[i]] = 1'b1;
      end
    end
    w_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]     <= '0;
        r_result[i] <= '0;
        r_waddr[i]  <= '0;
      end
    end else if (bus.wb_flush) begin
      // The beat is already refused through wb_allow_in; a retire shown on
      // the commit port this cycle is still taken, then the queue empties.
      r_count <= '0;
      r_head  <= r_tail;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < LANES; i++) begin
          if (bus.mem_lane_valid[i]) begin
            r_pc[w_slot[i]]     <= bus.mem_pc[32*i +: 32];
            r_result[w_slot[i]] <= bus.mem_final_result[DATA_W*i +: DATA_W];
            r_waddr[w_slot[i]]  <= bus.mem_reg_waddr[ADDR_W*i +: ADDR_W];
            r_we[w_slot[i]]     <= bus.mem_reg_we[i];
          end
        end
        r_tail <= r_tail + w_nvalid[PTR_W-1:0];
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + w_add - CNT_W'(w_pop);
    end
  end

  // Head entry drives the commit port and trace directly.
  assign bus.wb_allow_in       = w_allow_in;
  assign bus.wb_to_id_valid    = w_head_valid;
  assign bus.wb_reg_we         = w_head_valid & r_we[r_head];
  assign bus.wb_reg_waddr      = r_waddr[r_head];
  assign bus.wb_final_result   = r_result[r_head];
  assign bus.wb_pending_mask   = w_mask;
  assign bus.debug_wb_pc       = r_pc[r_head];
  assign bus.debug_wb_rf_wen   = {4{w_pop & r_we[r_head]}};
  assign bus.debug_wb_rf_wnum  = r_waddr[r_head];
  assign bus.debug_wb_rf_wdata = r_result[r_head];

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - scoreboard bench for wb_commit_queue

module tb_wb_commit_queue;
  localparam int LANES  = 2;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [31:0]       pc;
    logic [DATA_W-1:0] res;
    logic              we;
    logic [ADDR_W-1:0] wa;
  } entry_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_commit_queue_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_commit_queue #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  entry_t sb[$];
  entry_t lane_e [LANES];
  logic [LANES-1:0] drv_lv;
  logic drv_valid, drv_flush, drv_ready;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.mem_to_wb_valid = drv_valid;
    bus.mem_lane_valid  = drv_lv;
    bus.wb_flush        = drv_flush;
    bus.wb_commit_ready = drv_ready;
    for (int i = 0; i < LANES; i++) begin
      bus.mem_pc[32*i +: 32]                 = lane_e[i].pc;
      bus.mem_final_result[DATA_W*i +: DATA_W] = lane_e[i].res;
      bus.mem_reg_we[i]                      = lane_e[i].we;
      bus.mem_reg_waddr[ADDR_W*i +: ADDR_W]  = lane_e[i].wa;
    end
  endtask

  function automatic logic model_allow();
    return ((DEPTH - sb.size()) >= LANES) && !drv_flush;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (sb[i]) if (sb[i].we) m[sb[i].wa] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One cycle: compare DUT against the scoreboard, then advance both.
  task automatic step(input string tag);
    entry_t h;
    logic pop, acc;
    apply();
    #1;
    chk({tag, ".allow"}, bus.wb_allow_in, model_allow());
    chk({tag, ".valid"}, bus.wb_to_id_valid, sb.size() != 0);
    chk({tag, ".mask"}, bus.wb_pending_mask, model_mask());
    if (sb.size() != 0) begin
      h = sb[0];
      chk({tag, ".pc"}, bus.debug_wb_pc, h.pc);
      chk({tag, ".wnum"}, bus.debug_wb_rf_wnum, h.wa);
      chk({tag, ".wdata"}, bus.debug_wb_rf_wdata, h.res);
      chk({tag, ".we"}, bus.wb_reg_we, h.we);
      chk({tag, ".wen"}, bus.debug_wb_rf_wen, {4{drv_ready & h.we}});
    end else begin
      chk({tag, ".we_empty"}, bus.wb_reg_we, 1'b0);
      chk({tag, ".wen_empty"}, bus.debug_wb_rf_wen, 4'h0);
    end
    pop = (sb.size() != 0) && drv_ready;
    acc = drv_valid && model_allow();
    @(posedge clk);
    #1;
    if (pop) void'(sb.pop_front());
    if (drv_flush) sb.delete();
    else if (acc) begin
      for (int i = 0; i < LANES; i++) if (drv_lv[i]) sb.push_back(lane_e[i]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, bus.wb_to_id_valid, 1'b0);
    chk({tag, ".we"}, bus.wb_reg_we, 1'b0);
    chk({tag, ".waddr"}, bus.wb_reg_waddr, '0);
    chk({tag, ".result"}, bus.wb_final_result, '0);
    chk({tag, ".mask"}, bus.wb_pending_mask, '0);
    chk({tag, ".pc"}, bus.debug_wb_pc, '0);
    chk({tag, ".wen"}, bus.debug_wb_rf_wen, 4'h0);
  endtask

  task automatic idle();
    drv_valid = 1'b0;
    drv_lv    = '0;
    drv_flush = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] res,
                          input logic we, input logic [4:0] wa);
    lane_e[i].pc  = pc;
    lane_e[i].res = res;
    lane_e[i].we  = we;
    lane_e[i].wa  = wa;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout n_tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    drv_ready = 1'b0;
    for (int i = 0; i < LANES; i++) set_lane(i, '0, '0, 1'b0, '0);
    apply();
    repeat (2) @(posedge clk);
    #2;
    check_zero("rst");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst.allow", bus.wb_allow_in, 1'b1);

    // Single lane-0 beat, retires the cycle after it is accepted.
    drv_ready = 1'b1;
    drv_valid = 1'b1;
    drv_lv    = 2'b01;
    set_lane(0, 32'hBFC0_0000, 32'h1234, 1'b1, 5'd3);
    step("t1.beat");
    idle();
    chk("t1.mask3", bus.wb_pending_mask, 32'h8);
    chk("t1.wen", bus.debug_wb_rf_wen, 4'hF);
    step("t1.head");
    step("t1.after");

    // Two full beats with the port stalled, then in-order drain.
    drv_ready = 1'b0;
    drv_valid = 1'b1;
    drv_lv    = 2'b11;
    set_lane(0, 32'h100, 32'hA0, 1'b1, 5'd4);
    set_lane(1, 32'h104, 32'hA1, 1'b1, 5'd5);
    step("t2.beat0");
    set_lane(0, 32'h108, 32'hA2, 1'b0, 5'd6);
    set_lane(1, 32'h10C, 32'hA3, 1'b1, 5'd7);
    step("t2.beat1");
    idle();
    chk("t2.full_allow", bus.wb_allow_in, 1'b0);
    step("t2.full");
    drv_ready = 1'b1;
    for (int k = 0; k < 5; k++) step("t2.drain");

    // Only lane 1 valid.
    drv_valid = 1'b1;
    drv_lv    = 2'b10;
    set_lane(0, 32'h200, 32'hB0, 1'b1, 5'd8);
    set_lane(1, 32'h204, 32'hB1, 1'b1, 5'd9);
    step("t3.beat");
    idle();
    step("t3.ret");
    step("t3.after");

    // waddr 0 never shows in the mask; we=0 entry still traces its PC.
    drv_ready = 1'b0;
    drv_valid = 1'b1;
    drv_lv    = 2'b11;
    set_lane(0, 32'h300, 32'hC0, 1'b1, 5'd0);
    set_lane(1, 32'h304, 32'hC1, 1'b0, 5'd10);
    step("t4.beat");
    idle();
    step("t4.hold");
    drv_ready = 1'b1;
    for (int k = 0; k < 3; k++) step("t4.drain");

    // Flush with a retire and a beat in the same cycle.
    drv_ready = 1'b0;
    drv_valid = 1'b1;
    drv_lv    = 2'b11;
    set_lane(0, 32'h400, 32'hD0, 1'b1, 5'd11);
    set_lane(1, 32'h404, 32'hD1, 1'b1, 5'd12);
    step("t5.fill0");
    drv_lv = 2'b01;
    set_lane(0, 32'h408, 32'hD2, 1'b1, 5'd13);
    step("t5.fill1");
    drv_ready = 1'b1;
    drv_flush = 1'b1;
    drv_lv    = 2'b11;
    set_lane(0, 32'h40C, 32'hD3, 1'b1, 5'd14);
    set_lane(1, 32'h410, 32'hD4, 1'b1, 5'd15);
    step("t5.flush");
    idle();
    step("t5.empty");

    // Async reset pulse mid-drain.
    drv_ready = 1'b0;
    drv_valid = 1'b1;
    drv_lv    = 2'b11;
    set_lane(0, 32'h500, 32'hE0, 1'b1, 5'd16);
    set_lane(1, 32'h504, 32'hE1, 1'b1, 5'd17);
    step("t6.fill0");
    step("t6.fill1");
    idle();
    drv_ready = 1'b1;
    step("t6.drain");
    #2;
    resetn = 1'b0;
    #1;
    check_zero("t6.async");
    sb.delete();
    #1;
    resetn = 1'b1;

    // 20 accepted random beats, at least 20 entries through a 4-deep queue.
    for (int b = 0; b < 20; b++) begin
      for (int g = 0; g < 8 && !((DEPTH - sb.size()) >= LANES); g++) begin
        idle();
        drv_ready = 1'b1;
        step("t7.make_room");
      end
      drv_valid = 1'b1;
      drv_flush = 1'b0;
      drv_lv    = 2'($urandom_range(1, 3));
      drv_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < LANES; i++)
        set_lane(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      step("t7.beat");
    end
    idle();
    drv_ready = 1'b1;
    for (int k = 0; k < 12 && sb.size() != 0; k++) step("t7.drain");
    step("t7.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Parametrised multi-lane writeback stage for the 5-stage pipeline. Accepts up to LANES results per cycle from the MEM stage, holds them in an in-order DEPTH-entry queue, and retires one entry per cycle to the single register-file write port when the port is ready. Publishes a pending-write mask for ID hazard detection and drives the standard debug trace.

## Interface

- LANES, 2: results offered per MEM beat; ≥1.
- DEPTH, 4: queue entries; power of two, ≥ LANES.
- DATA_W, 32: result width.
- ADDR_W, 5: register address width.
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_to_wb_valid  in  1  MEM beat valid.
- wb_allow_in  out  1  WB accepts a beat this cycle.
- mem_lane_valid  in  LANES  per-lane valid within a beat; lane 0 is oldest.
- mem_pc  in  LANES*32  per-lane PC, lane i at [32i+31:32i].
- mem_final_result  in  LANES*DATA_W  per-lane result.
- mem_reg_we  in  LANES  per-lane register write enable.
- mem_reg_waddr  in  LANES*ADDR_W  per-lane destination.
- wb_flush  in  1  discard all queued entries and the current beat.
- wb_commit_ready  in  1  register-file port accepts a write this cycle.
- wb_to_id_valid  out  1  head entry valid (queue non-empty).
- wb_reg_we  out  1  head write enable, gated with wb_to_id_valid.
- wb_reg_waddr  out  ADDR_W  head destination.
- wb_final_result  out  DATA_W  head result.
- wb_pending_mask  out  2**ADDR_W  bit r set if any queued entry has we=1, waddr=r; bit 0 always 0.
- debug_wb_pc  out  32  PC of entry retiring this cycle.
- debug_wb_rf_wen  out  4  {4{wb_to_id_valid & wb_commit_ready & head_we}}.
- debug_wb_rf_wnum  out  ADDR_W  = wb_reg_waddr.
- debug_wb_rf_wdata  out  DATA_W  = wb_final_result.

## Operation

- Storage: circular buffer of DEPTH entries {pc, result, we, waddr}; head pointer, tail pointer, count (0..DEPTH).
- wb_allow_in = (DEPTH − count ≥ LANES) & ~wb_flush. Depends only on registered count; no combinational path from wb_commit_ready or MEM inputs.
- Accept: mem_to_wb_valid & wb_allow_in. Valid lanes are compacted in lane order into tail, tail+1, …; invalid lanes consume no slot. A beat with all lane_valid=0 is accepted and writes nothing.
- Entries with we=0 are queued and retired (they produce a debug PC, wen=0).
- Retire (pop): wb_to_id_valid & wb_commit_ready. Head advances by one. Exactly one retire per cycle maximum.
- Same-cycle accept and retire allowed: count_next = count + n_valid_lanes − pop.
- Pointers wrap modulo DEPTH (natural wrap of log2(DEPTH)-bit pointers).
- Outputs wb_* and debug_* are combinational from the head entry; wb_pending_mask is combinational over all valid entries.
- wb_flush (synchronous, highest priority): next edge sets count=0, head=tail; concurrent beat dropped; concurrent retire still happens (debug shows it). wb_allow_in is 0 during flush.

## Timing

- Async reset: count=0, head=tail=0, all entry fields 0. Hence wb_to_id_valid=0, wb_reg_we=0, wb_reg_waddr=0, wb_final_result=0, wb_pending_mask=0, debug_wb_pc=0, debug_wb_rf_wen=0, wb_allow_in=1 (after resetn deasserts, given DEPTH ≥ LANES).
- Reset asserted mid-operation clears the queue immediately; in-flight entries are lost.
- Latency: entry accepted at edge N into an empty queue is head in cycle N+1; retires at edge N+1 if wb_commit_ready.
- Throughput: one retire/cycle; sustained LANES-wide input stalls via wb_allow_in once count > DEPTH − LANES.
- Full (count=DEPTH): wb_allow_in=0; retire still permitted.
- Empty: wb_to_id_valid=0, all debug wen 0, wb_commit_ready ignored.

## Test plan

- Reset then single lane-0 beat {pc=0xBFC00000, result=0x1234, we=1, waddr=3}, commit_ready=1 -> next cycle wb_to_id_valid=1, debug_wb_rf_wen=4'hF, wnum=3, wdata=0x1234; mask bit 3 set that cycle only.
- LANES=2, DEPTH=4, commit_ready=0, two full beats -> count=4, wb_allow_in=0; raise ready -> entries retire in order lane0/lane1/lane0/lane1, one per cycle; wb_allow_in returns 1 when count ≤2.
- Beat with lane_valid=2'b10 -> only lane 1 enqueued, count +1, retired pc equals lane-1 pc.
- Entry with waddr=0, we=1 -> mask bit 0 stays 0; entry with we=0 retires with debug_wb_rf_wen=0, debug_wb_pc correct.
- Fill 3 entries, assert wb_flush with commit_ready=1 and a valid beat -> head retires once, next cycle count=0, wb_to_id_valid=0, beat not stored.
- Pulse resetn low asynchronously mid-drain (between edges) -> all outputs 0 immediately; 20-beat random stream afterwards wraps pointers ≥5 times with retire order equal to accept order.
